aes_stream_sequencer: RTL

Word-stream front end for `aes_core`: accepts 32-bit words over a valid/ready slave port and packs four of them into a 128-bit block. It drives the core's init/mode/data/key inputs, captures the one-cycle result pulse, and serialises the 128-bit result back out as four 32-bit words on a valid/ready master port. It sits directly upstream and downstream of `aes_core`, between the bus/UART word interface and the cipher.

---
 rtl/aes_stream_sequencer_pkg.sv | 52 +++++
 rtl/aes_cbc_chain.sv | 36 +++
 rtl/aes_stream_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/aes_stream_sequencer_pkg.sv
// Shared definitions for the AES word-stream sequencer: block geometry,
// cipher direction encoding, FSM state type and word pack/unpack helpers.
package aes_stream_sequencer_pkg;

    localparam int unsigned AES_WORDS_PER_BLOCK = 4;
    localparam int unsigned AES_WORD_W          = 32;
    localparam int unsigned AES_BLOCK_W         = 128;
    localparam int unsigned AES_CNT_W           = $clog2(AES_WORDS_PER_BLOCK);

    localparam logic ENCRYPT = 1'b1;
    localparam logic DECRYPT = 1'b0;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } aes_seq_state_t;

    // Word idx of a block; word 0 is the most significant word.
    function automatic logic [AES_WORD_W-1:0] block_word(
        input logic [AES_BLOCK_W-1:0] blk,
        input logic [AES_CNT_W-1:0]   idx
    );
        logic [AES_WORD_W-1:0] word;
        case (idx)
            AES_CNT_W'(0): word = blk[127:96];
            AES_CNT_W'(1): word = blk[95:64];
            AES_CNT_W'(2): word = blk[63:32];
            default:       word = blk[31:0];
        endcase
        return word;
    endfunction

    // Replace word idx of a block; word 0 is the most significant word.
    function automatic logic [AES_BLOCK_W-1:0] block_insert(
        input logic [AES_BLOCK_W-1:0] blk,
        input logic [AES_CNT_W-1:0]   idx,
        input logic [AES_WORD_W-1:0]  word
    );
        logic [AES_BLOCK_W-1:0] tmp;
        tmp = blk;
        case (idx)
            AES_CNT_W'(0): tmp[127:96] = word;
            AES_CNT_W'(1): tmp[95:64]  = word;
            AES_CNT_W'(2): tmp[63:32]  = word;
            default:       tmp[31:0]   = word;
        endcase
        return tmp;
    endfunction

endpackage

// File: rtl/aes_cbc_chain.sv
// CBC chain register and the XOR muxing around aes_core.
// Encrypt: core input = block ^ chain, chain <- ciphertext.
// Decrypt: result = core output ^ chain, chain <- received ciphertext block.
module aes_cbc_chain
    import aes_stream_sequencer_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   mode_in,
    input  logic                   iv_load_in,
    input  logic [AES_BLOCK_W-1:0] iv_in,
    input  logic                   capture_in,
    input  logic [AES_BLOCK_W-1:0] blk_new_in,
    input  logic [AES_BLOCK_W-1:0] blk_saved_in,
    input  logic [AES_BLOCK_W-1:0] core_result_in,
    output logic [AES_BLOCK_W-1:0] core_data_out,
    output logic [AES_BLOCK_W-1:0] result_out
);

    logic [AES_BLOCK_W-1:0] r_chain;

    // Chain register: IV load at block boundary, update on result capture.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_chain <= '0;
        end else if (iv_load_in) begin
            r_chain <= iv_in;
        end else if (capture_in) begin
            r_chain <= (mode_in == ENCRYPT) ? core_result_in : blk_saved_in;
        end
    end

    assign core_data_out = (mode_in == ENCRYPT) ? (blk_new_in ^ r_chain) : blk_new_in;
    assign result_out    = (mode_in == DECRYPT) ? (core_result_in ^ r_chain) : core_result_in;

endmodule

// File: rtl/aes_stream_sequencer.sv
// Word-stream front end for aes_core: packs four 32-bit words into a block,
// starts the core, captures its result and serialises it back as four words.
// Optional feature macro AES_SEQ_CBC_EN selects CBC chaining; default is ECB.
module aes_stream_sequencer
    import aes_stream_sequencer_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   mode_in,
    input  logic [AES_BLOCK_W-1:0] key_in,
    input  logic [AES_BLOCK_W-1:0] iv_in,
    input  logic                   iv_load_in,
    input  logic [AES_WORD_W-1:0]  s_data_in,
    input  logic                   s_valid_in,
    output logic                   s_ready_out,
    output logic [AES_WORD_W-1:0]  m_data_out,
    output logic                   m_valid_out,
    input  logic                   m_ready_in,
    output logic                   core_mode_out,
    output logic                   core_init_out,
    output logic [AES_BLOCK_W-1:0] core_data_out,
    output logic [AES_BLOCK_W-1:0] core_key_out,
    input  logic [AES_BLOCK_W-1:0] core_data_in,
    input  logic                   core_valid_in,
    output logic                   busy_out
);

    localparam logic [AES_CNT_W-1:0] LAST_IDX = AES_CNT_W'(AES_WORDS_PER_BLOCK - 1);

    aes_seq_state_t         r_state, w_state_nxt;
    logic [AES_CNT_W-1:0]   r_in_cnt, w_in_cnt_nxt;
    logic [AES_CNT_W-1:0]   r_out_cnt, w_out_cnt_nxt;
    logic [AES_BLOCK_W-1:0] r_block, w_block_nxt;
    logic [AES_BLOCK_W-1:0] r_result, w_result_nxt;
    logic                   r_mode, w_mode_nxt;
    logic [AES_BLOCK_W-1:0] r_key, w_key_nxt;
    logic [AES_BLOCK_W-1:0] r_core_data, w_core_data_nxt;
    logic [AES_WORD_W-1:0]  r_m_data, w_m_data_nxt;
    logic                   r_s_ready, w_s_ready_nxt;
    logic                   r_m_valid, w_m_valid_nxt;
    logic                   r_init, w_init_nxt;
    logic                   r_busy, w_busy_nxt;

    logic                   w_s_fire;
    logic                   w_m_fire;
    logic                   w_capture;
    logic [AES_BLOCK_W-1:0] w_blk_ins;
    logic [AES_BLOCK_W-1:0] w_core_src;
    logic [AES_BLOCK_W-1:0] w_core_result;

    assign w_s_fire  = s_valid_in & r_s_ready;
    assign w_m_fire  = r_m_valid & m_ready_in;
    assign w_capture = (r_state == S_WAIT) & core_valid_in;
    assign w_blk_ins = block_insert(r_block, r_in_cnt, s_data_in);

`ifdef AES_SEQ_CBC_EN
    logic w_iv_load;
    assign w_iv_load = iv_load_in & (r_state == S_FILL) & (r_in_cnt == '0);

    aes_cbc_chain u_chain (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mode_in        (r_mode),
        .iv_load_in     (w_iv_load),
        .iv_in          (iv_in),
        .capture_in     (w_capture),
        .blk_new_in     (w_blk_ins),
        .blk_saved_in   (r_block),
        .core_result_in (core_data_in),
        .core_data_out  (w_core_src),
        .result_out     (w_core_result)
    );
`else
    logic w_unused_ecb;
    assign w_unused_ecb  = ^{iv_in, iv_load_in};
    assign w_core_src    = w_blk_ins;
    assign w_core_result = core_data_in;
`endif

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_in_cnt_nxt    = r_in_cnt;
        w_out_cnt_nxt   = r_out_cnt;
        w_block_nxt     = r_block;
        w_result_nxt    = r_result;
        w_mode_nxt      = r_mode;
        w_key_nxt       = r_key;
        w_core_data_nxt = r_core_data;
        w_m_data_nxt    = r_m_data;
        w_init_nxt      = 1'b0;

        unique case (r_state)
            S_FILL: begin
                if (w_s_fire) begin
                    w_block_nxt  = w_blk_ins;
                    w_in_cnt_nxt = r_in_cnt + AES_CNT_W'(1);
                    if (r_in_cnt == '0) begin
                        w_mode_nxt = mode_in;
                        w_key_nxt  = key_in;
                    end
                    if (r_in_cnt == LAST_IDX) begin
                        w_core_data_nxt = w_core_src;
                        w_init_nxt      = 1'b1;
                        w_state_nxt     = S_START;
                    end
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (core_valid_in) begin
                    w_result_nxt  = w_core_result;
                    w_out_cnt_nxt = '0;
                    w_m_data_nxt  = block_word(w_core_result, '0);
                    w_state_nxt   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_m_fire) begin
                    w_out_cnt_nxt = r_out_cnt + AES_CNT_W'(1);
                    if (r_out_cnt == LAST_IDX) begin
                        w_state_nxt = S_FILL;
                    end else begin
                        w_m_data_nxt = block_word(r_result, r_out_cnt + AES_CNT_W'(1));
                    end
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase

        w_s_ready_nxt = (w_state_nxt == S_FILL);
        w_m_valid_nxt = (w_state_nxt == S_DRAIN);
        w_busy_nxt    = !((w_state_nxt == S_FILL) && (w_in_cnt_nxt == '0));
    end

    // Datapath and output registers; reset clears block, result and outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_block     <= '0;
            r_result    <= '0;
            r_mode      <= 1'b0;
            r_key       <= '0;
            r_core_data <= '0;
            r_m_data    <= '0;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_init      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_cnt    <= w_in_cnt_nxt;
            r_out_cnt   <= w_out_cnt_nxt;
            r_block     <= w_block_nxt;
            r_result    <= w_result_nxt;
            r_mode      <= w_mode_nxt;
            r_key       <= w_key_nxt;
            r_core_data <= w_core_data_nxt;
            r_m_data    <= w_m_data_nxt;
            r_s_ready   <= w_s_ready_nxt;
            r_m_valid   <= w_m_valid_nxt;
            r_init      <= w_init_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign s_ready_out   = r_s_ready;
    assign m_valid_out   = r_m_valid;
    assign m_data_out    = r_m_data;
    assign core_init_out = r_init;
    assign core_mode_out = r_mode;
    assign core_key_out  = r_key;
    assign core_data_out = r_core_data;
    assign busy_out      = r_busy;

endmodule
